// File: rtl/nios_test_nios2_qsys_0_mult_seq.sv
// Sequential 32x32 multiplier for Nios II MUL/MULXUU/MULXSU/MULXSS built on one
// registered 16x16 unsigned multiplier; one partial product issued per cycle.
module nios_test_nios2_qsys_0_mult_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSS = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] prod_q, prod_d;
    logic [1:0]  prod_idx_q, prod_idx_d;
    logic        prod_vld_q, prod_vld_d;

    logic [15:0] mul_a, mul_b;
    logic [31:0] mul_p;
    logic [63:0] acc_add;
    logic [1:0]  last_cnt;
    logic [31:0] hi_fix;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            prod_idx_q <= '0;
            prod_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            prod_idx_q <= prod_idx_d;
            prod_vld_q <= prod_vld_d;
        end
    end

    // Operand halves in order LL, HL, LH, HH.
    always_comb begin
        mul_a = a_q[15:0];
        mul_b = b_q[15:0];
        case (cnt_q)
            2'd0: begin mul_a = a_q[15:0];  mul_b = b_q[15:0];  end
            2'd1: begin mul_a = a_q[31:16]; mul_b = b_q[15:0];  end
            2'd2: begin mul_a = a_q[15:0];  mul_b = b_q[31:16]; end
            default: begin mul_a = a_q[31:16]; mul_b = b_q[31:16]; end
        endcase
    end

    assign mul_p = {16'b0, mul_a} * {16'b0, mul_b};

    always_comb begin
        acc_add = 64'b0;
        if (prod_vld_q) begin
            case (prod_idx_q)
                2'd0:    acc_add = {32'b0, prod_q};
                2'd1,
                2'd2:    acc_add = {16'b0, prod_q, 16'b0};
                default: acc_add = {prod_q, 32'b0};
            endcase
        end
    end

    // The HH term only touches bits 63:32, so MUL stops after three pairs.
    assign last_cnt = (op_q == OP_MUL) ? 2'd2 : 2'd3;

    assign hi_fix = acc_q[63:32]
                  - (a_q[31] ? b_q : 32'b0)
                  - ((op_q == OP_MULXSS) && b_q[31] ? a_q : 32'b0);

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        prod_idx_d = prod_idx_q;
        prod_vld_d = prod_vld_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = in_src1;
                    b_d        = in_src2;
                    op_d       = in_op;
                    cnt_d      = 2'd0;
                    acc_d      = 64'b0;
                    prod_vld_d = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                acc_d      = acc_q + acc_add;
                prod_d     = mul_p;
                prod_idx_d = cnt_q;
                prod_vld_d = 1'b1;
                cnt_d      = cnt_q + 2'd1;
                if (cnt_q == last_cnt) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                acc_d      = acc_q + acc_add;
                prod_vld_d = 1'b0;
                state_d    = op_q[1] ? FIX : DONE;
            end
            FIX: begin
                acc_d   = {hi_fix, acc_q[31:0]};
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_result = !out_valid         ? 32'b0 :
                        (op_q == OP_MUL)   ? acc_q[31:0] : acc_q[63:32];

endmodule

// File: tb/tb_nios_test_nios2_qsys_0_mult_seq.sv
// Scoreboard bench: stimulus pushes expected result/latency, monitor pops and compares on out handshake.
module tb_nios_test_nios2_qsys_0_mult_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    nios_test_nios2_qsys_0_mult_seq dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   seen_valid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor samples 2 time units after the falling edge, after stimulus settles.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (!out_valid && out_result !== 32'h0) begin
                    total++; bad++;
                    $display("FAIL result_zero_when_idle: got 0x%08h expected 0x00000000", out_result);
                end
                if (out_valid && exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_out_valid: got out_valid=1 expected 0");
                    seen_valid = 1;
                end else if (out_valid && !seen_valid) begin
                    seen_valid = 1;
                    e = exp_q[0];
                    check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("result", out_result, e.res);
                    end
                    seen_valid = 0;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input bit push);
        exp_t e;
        int   n;
        @(negedge clk); #1;
        in_op = op; in_src1 = a; in_src2 = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        @(negedge clk);
        if (push) begin
            e.res = res; e.lat = lat; e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk); n++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    logic [31:0] held;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_src1 = '0; in_src2 = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_result", out_result, 32'h0);
        reset = 1'b0;

        issue(2'b00, 32'h00010003, 32'h00020005, 32'h000B000F, 4, 1); wait_drain();
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 1); wait_drain();
        issue(2'b11, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 6, 1); wait_drain();
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 6, 1); wait_drain();
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4, 1); wait_drain();
        issue(2'b11, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 6, 1); wait_drain();
        issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 6, 1); wait_drain();
        issue(2'b01, 32'h80000000, 32'h00000004, 32'h00000002, 5, 1); wait_drain();
        issue(2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 6, 1); wait_drain();

        // Back-pressure: result held while a new request is ignored.
        out_ready = 1'b0;
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 1);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin @(negedge clk); #1; n++; end
        end
        check("bp_valid_rise", 32'(out_valid), 32'd1);
        held = out_result;
        in_op = 2'b00; in_src1 = 32'd3; in_src2 = 32'd3; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_result", out_result, held);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk); #1;
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        check("bp_out_valid_after", 32'(out_valid), 32'd0);
        wait_drain();

        // Reset mid-ISSUE aborts the MULXSS; no result may appear.
        issue(2'b11, 32'h12345678, 32'h87654321, 32'h0, 6, 0);
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        repeat (8) @(negedge clk);
        issue(2'b00, 32'd7, 32'd6, 32'h0000002A, 4, 1); wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios_test_nios2_qsys_0_mult_seq.md
NIOS_TEST_NIOS2_QSYS_0_MULT_SEQ -- requirements
Module: nios_test_nios2_qsys_0_mult_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; no other clock or reset input exists.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 in_op  input  2  operation: 00 MUL (low 32), 01 MULXUU, 10 MULXSU, 11 MULXSS (high 32).
REQ-007 in_src1  input  32  operand A; signed for MULXSU and MULXSS.
REQ-008 in_src2  input  32  operand B; signed for MULXSS only.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 out_result  output  32  selected 32-bit result word.

Function
REQ-012 The block SHALL compute the product with one internal 16x16 unsigned multiplier whose product is registered once (1-cycle latency), issuing one partial product per cycle.
REQ-013 Acceptance SHALL occur on the edge where in_valid and in_ready are both 1; this edge latches in_src1, in_src2 and in_op.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 States SHALL be IDLE, ISSUE, DRAIN, FIX and DONE.
REQ-016 IDLE SHALL go to ISSUE on acceptance, with the issue counter at 0 and the 64-bit accumulator at 0.
REQ-017 ISSUE SHALL present one pair per cycle in this order: A[15:0]*B[15:0], A[31:16]*B[15:0], A[15:0]*B[31:16], A[31:16]*B[31:16].
REQ-018 For MUL, ISSUE SHALL stop after the third pair, because the HH term cannot affect the low 32 bits.
REQ-019 On each edge following an issue, the accumulator SHALL add the registered product shifted left by 0, 16, 16 and 32 respectively, modulo 2^64.
REQ-020 After the last issue, ISSUE SHALL go to DRAIN; DRAIN performs the final add.
REQ-021 DRAIN SHALL go to FIX for MULXSU and MULXSS, and to DONE otherwise.
REQ-022 FIX SHALL adjust hi = acc[63:32], modulo 2^32:
- subtract B if A[31]=1 (MULXSU and MULXSS);
- subtract A if B[31]=1 (MULXSS only).
Both subtractions happen in the same cycle. FIX then goes to DONE.
REQ-023 Latency from the acceptance edge to out_valid=1 SHALL be 4 cycles for MUL, 5 for MULXUU, and 6 for MULXSU and MULXSS.
REQ-024 In DONE, out_valid SHALL be 1 and out_result SHALL equal acc[31:0] for MUL, or the (corrected) hi word otherwise.
REQ-025 out_valid and out_result SHALL be held stable until out_ready=1; DONE then goes to IDLE on that edge.
REQ-026 A new request SHALL NOT be accepted in the same cycle as the out handshake.
REQ-027 in_valid and the in_* inputs SHALL be ignored outside IDLE; latched operands SHALL NOT change mid-operation.
REQ-028 out_ready SHALL be ignored outside DONE.
REQ-029 out_result SHALL be 0 whenever out_valid=0.

Reset
REQ-030 While reset=1 at a rising edge, the next state SHALL be:
- state IDLE;
- accumulator, latched operands, issue counter and multiplier register at 0;
- in_ready=1, out_valid=0, out_result=0.
REQ-031 Reset SHALL take priority over every transition, including acceptance and the out handshake.
REQ-032 Reset in any non-IDLE state SHALL abort the operation; no result is produced for it.

Verification
REQ-033 MUL, src1=0x00010003, src2=0x00020005 -> out_result=0x000B000F; out_valid 4 cycles after acceptance.
REQ-034 MULXUU, 0xFFFFFFFF*0xFFFFFFFF -> out_result=0xFFFFFFFE; latency 5.
REQ-035 Signed cases, latency 6:
- MULXSS, src1=0xFFFFFFFF, src2=0x00000002 -> out_result=0xFFFFFFFF;
- MULXSU, src1=0x80000000, src2=0xFFFFFFFF -> out_result=0x80000000.
REQ-036 Back-pressure, after a MULXUU result is ready:
- hold out_ready=0 for 3 cycles while in_valid=1 with new operands;
- expect out_valid/out_result stable, in_ready=0 and no acceptance;
- on out_ready=1, expect in_ready=1 on the next cycle.
REQ-037 Reset mid-operation:
- assert reset for 1 cycle during ISSUE of a MULXSS;
- expect in_ready=1 and out_valid=0 on the next cycle, and no spurious out_valid afterwards;
- a following MUL of 7*6 SHALL return 0x0000002A.
